// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Two-master / one-slave arbiter for the system memory bus. One transaction
//   is in flight at a time: the winning master's command fields are latched
//   onto the shared bus, a one-cycle command pulse goes to the slave, and the
//   slave's completion (or a timeout) is returned only to the owning master.
//   Contention is resolved round-robin: after every response the other master
//   gets priority. Master 0 wins the first contention after reset.
//
// Parameters
//   TIMEOUT_CYCLES : WAIT cycles without i_bus_DV before abort (>= 2)
//   CNT_W          : timeout counter width (>= clog2(TIMEOUT_CYCLES+1))
//
// Ports
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_mX_req              : level request, held until o_mX_DV
//   i_mX_address/data     : command address / write data
//   i_mX_bhw              : byte/half/word select
//   i_mX_write_notread    : 1 = write
//   o_mX_data/DV/err      : response data, one-cycle pulse, timeout flag
//   o_bus_*               : command to the slave, o_bus_DV is the pulse
//   i_bus_data/DV         : slave read data and completion pulse
//   o_owner               : current or last bus owner
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_req,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_data,
    input  logic [2:0]  i_m0_bhw,
    input  logic        i_m0_write_notread,
    output logic [31:0] o_m0_data,
    output logic        o_m0_DV,
    output logic        o_m0_err,
    input  logic        i_m1_req,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_data,
    input  logic [2:0]  i_m1_bhw,
    input  logic        i_m1_write_notread,
    output logic [31:0] o_m1_data,
    output logic        o_m1_DV,
    output logic        o_m1_err,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_data,
    output logic [2:0]  o_bus_bhw,
    output logic        o_bus_write_notread,
    output logic        o_bus_DV,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV,
    output logic        o_owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic             prio;      // master preferred when both request
    logic [CNT_W-1:0] cnt;       // WAIT cycles elapsed in this transaction

    logic             grant;
    logic             resp_done;
    logic             resp_err;
    logic [31:0]      resp_data;

    // Master 1 wins if it is the only requester, or both request and it has priority.
    assign grant     = i_m1_req & (~i_m0_req | prio);

    // A completion on the last timeout cycle still counts as success.
    assign resp_done = i_bus_DV | (cnt == CNT_LAST);
    assign resp_err  = ~i_bus_DV;
    assign resp_data = i_bus_DV ? i_bus_data : 32'd0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state               <= IDLE;
            prio                <= 1'b0;
            cnt                 <= '0;
            o_owner             <= 1'b0;
            o_bus_address       <= 32'd0;
            o_bus_data          <= 32'd0;
            o_bus_bhw           <= 3'd0;
            o_bus_write_notread <= 1'b0;
            o_bus_DV            <= 1'b0;
            o_m0_data           <= 32'd0;
            o_m0_DV             <= 1'b0;
            o_m0_err            <= 1'b0;
            o_m1_data           <= 32'd0;
            o_m1_DV             <= 1'b0;
            o_m1_err            <= 1'b0;
        end else begin
            // Pulses and the error flag last a single cycle unless re-set below.
            o_bus_DV <= 1'b0;
            o_m0_DV  <= 1'b0;
            o_m0_err <= 1'b0;
            o_m1_DV  <= 1'b0;
            o_m1_err <= 1'b0;

            case (state)
                // IDLE: sample requests and latch the winner's command
                IDLE: begin
                    if (i_m0_req || i_m1_req) begin
                        o_owner             <= grant;
                        o_bus_address       <= grant ? i_m1_address       : i_m0_address;
                        o_bus_data          <= grant ? i_m1_data          : i_m0_data;
                        o_bus_bhw           <= grant ? i_m1_bhw           : i_m0_bhw;
                        o_bus_write_notread <= grant ? i_m1_write_notread : i_m0_write_notread;
                        o_bus_DV            <= 1'b1;
                        state               <= ISSUE;
                    end
                end

                // ISSUE: command pulse is on the bus this cycle
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end

                // WAIT: hold the command until completion or timeout
                WAIT: begin
                    if (resp_done) begin
                        state <= RESP;
                        if (o_owner) begin
                            o_m1_DV   <= 1'b1;
                            o_m1_data <= resp_data;
                            o_m1_err  <= resp_err;
                        end else begin
                            o_m0_DV   <= 1'b1;
                            o_m0_data <= resp_data;
                            o_m0_err  <= resp_err;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // RESP: response pulse visible to the owner; hand priority over
                RESP: begin
                    cnt   <= '0;
                    prio  <= ~o_owner;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Self-checking bench for bus_arbiter. A small reference model (priority
//   bit, pending requests, expected latencies computed from the slave delay)
//   predicts owner, bus command and response for each transaction.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_address = '0, m0_data = '0, m1_address = '0, m1_data = '0;
    logic [2:0]  m0_bhw = '0, m1_bhw = '0;
    logic        m0_wnr = 1'b0, m1_wnr = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_dv = 1'b0;

    logic [31:0] o_m0_data, o_m1_data, o_bus_address, o_bus_data;
    logic        o_m0_DV, o_m0_err, o_m1_DV, o_m1_err;
    logic [2:0]  o_bus_bhw;
    logic        o_bus_write_notread, o_bus_DV, o_owner;

    int checks = 0;
    int failures = 0;
    logic prio_model = 1'b0;

    bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(m0_req), .i_m0_address(m0_address), .i_m0_data(m0_data),
        .i_m0_bhw(m0_bhw), .i_m0_write_notread(m0_wnr),
        .o_m0_data(o_m0_data), .o_m0_DV(o_m0_DV), .o_m0_err(o_m0_err),
        .i_m1_req(m1_req), .i_m1_address(m1_address), .i_m1_data(m1_data),
        .i_m1_bhw(m1_bhw), .i_m1_write_notread(m1_wnr),
        .o_m1_data(o_m1_data), .o_m1_DV(o_m1_DV), .o_m1_err(o_m1_err),
        .o_bus_address(o_bus_address), .o_bus_data(o_bus_data),
        .o_bus_bhw(o_bus_bhw), .o_bus_write_notread(o_bus_write_notread),
        .o_bus_DV(o_bus_DV), .i_bus_data(bus_rdata), .i_bus_DV(bus_dv),
        .o_owner(o_owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [68:0] bus_now();
        return {o_owner, o_bus_address, o_bus_data, o_bus_bhw, o_bus_write_notread};
    endfunction

    function automatic logic [68:0] exp_bus(input logic owner);
        return owner ? {1'b1, m1_address, m1_data, m1_bhw, m1_wnr}
                     : {1'b0, m0_address, m0_data, m0_bhw, m0_wnr};
    endfunction

    function automatic logic [137:0] all_outs();
        return {o_m0_data, o_m0_DV, o_m0_err, o_m1_data, o_m1_DV, o_m1_err,
                o_bus_address, o_bus_data, o_bus_bhw, o_bus_write_notread,
                o_bus_DV, o_owner};
    endfunction

    // Response latency in cycles after the ISSUE cycle: slave answers in WAIT
    // cycle 'lat' (0-based); no answer within TO WAIT cycles means timeout.
    function automatic int exp_resp_lat(input int lat);
        return (lat < TO) ? lat + 2 : TO + 1;
    endfunction

    // Drives one transaction from IDLE (called #1 after a rising edge) and
    // returns observations; the caller compares them with the model.
    task automatic run_txn(
        input  logic r0, input logic r1, input int lat, input logic [31:0] rdata,
        input  logic keep_req, input logic chg_addr,
        output int issue_lat, output logic [68:0] snap, output int resp_lat,
        output logic resp_owner, output logic [31:0] resp_data, output logic resp_err,
        output logic stable, output logic quiet);
        issue_lat = -1; snap = '0; resp_lat = -1; resp_owner = 1'b0;
        resp_data = '0; resp_err = 1'b0; stable = 1'b1; quiet = 1'b1;
        m0_req = r0; m1_req = r1;
        for (int i = 1; i <= 4 && issue_lat < 0; i++) begin
            @(posedge clk); #1;
            if (o_bus_DV) issue_lat = i;
        end
        if (issue_lat < 0) return;
        snap = bus_now();
        for (int k = 1; k <= TO + 4 && resp_lat < 0; k++) begin
            @(posedge clk); #1;
            if (bus_now() !== snap) stable = 1'b0;
            if (o_bus_DV) quiet = 1'b0;
            if (o_m0_DV || o_m1_DV) begin
                resp_lat   = k;
                resp_owner = o_m1_DV;
                resp_data  = o_m1_DV ? o_m1_data : o_m0_data;
                resp_err   = o_m1_DV ? o_m1_err : o_m0_err;
                if (o_m0_DV && o_m1_DV) quiet = 1'b0;
                bus_dv = 1'b0;
                if (!keep_req) begin
                    if (o_m1_DV) m1_req = 1'b0;
                    else         m0_req = 1'b0;
                end
            end else begin
                bus_dv    = (k == lat + 1);
                bus_rdata = (k == lat + 1) ? rdata : $urandom;
                if (chg_addr && k == 1) m0_address = 32'h20;
            end
        end
        bus_dv = 1'b0;
        @(posedge clk); #1;
        if (o_m0_DV || o_m1_DV || o_bus_DV) quiet = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++; $display("FAIL reset_async: outputs=%h required 0", all_outs());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++; $display("FAIL reset_idle: outputs=%h required 0", all_outs());
        end
        prio_model = 1'b0;
    endtask

    task automatic test_single_read();
        int il, rl; logic [68:0] sn, eb; logic ro, re, st, qu; logic [31:0] rd;
        m0_address = 32'h100; m0_bhw = 3'b010; m0_wnr = 1'b0; m0_data = $urandom;
        eb = exp_bus(1'b0);
        // Slave answers 2 cycles after the command pulse = WAIT cycle 1.
        run_txn(1'b1, 1'b0, 1, 32'hDEADBEEF, 1'b0, 1'b0, il, sn, rl, ro, rd, re, st, qu);
        checks++; if (il !== 1) begin failures++; $display("FAIL read_issue_lat: got %0d required 1", il); end
        checks++; if (sn !== eb) begin failures++; $display("FAIL read_bus: got %h required %h", sn, eb); end
        checks++; if (rl !== 3) begin failures++; $display("FAIL read_resp_lat: got %0d required 3", rl); end
        checks++; if ({ro, rd, re} !== {1'b0, 32'hDEADBEEF, 1'b0}) begin
            failures++; $display("FAIL read_resp: owner=%b data=%h err=%b required 0 deadbeef 0", ro, rd, re); end
        checks++; if ({st, qu} !== 2'b11) begin
            failures++; $display("FAIL read_clean: stable=%b quiet=%b required 1 1", st, qu); end
        prio_model = 1'b1;
    endtask

    task automatic test_single_write();
        int il, rl; logic [68:0] sn, eb; logic ro, re, st, qu; logic [31:0] rd, sv;
        sv = $urandom;
        m1_address = 32'h40; m1_data = 32'h12345678; m1_bhw = 3'b100; m1_wnr = 1'b1;
        eb = exp_bus(1'b1);
        run_txn(1'b0, 1'b1, 0, sv, 1'b0, 1'b0, il, sn, rl, ro, rd, re, st, qu);
        checks++; if (sn !== eb) begin failures++; $display("FAIL write_bus: got %h required %h", sn, eb); end
        checks++; if ({il, rl} !== {32'd1, 32'd2}) begin
            failures++; $display("FAIL write_lat: issue=%0d resp=%0d required 1 2", il, rl); end
        checks++; if ({ro, rd, re} !== {1'b1, sv, 1'b0}) begin
            failures++; $display("FAIL write_resp: owner=%b data=%h err=%b required 1 %h 0", ro, rd, re, sv); end
        checks++; if ({o_owner, o_m0_data} !== {1'b1, 32'hDEADBEEF}) begin
            failures++; $display("FAIL write_owner_hold: owner=%b m0_data=%h required 1 deadbeef", o_owner, o_m0_data); end
        prio_model = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic seen = 1'b0;
        m0_req = 1'b1; m0_address = 32'h300;
        @(posedge clk); #1;   // ISSUE
        @(posedge clk); #1;   // WAIT
        #2 rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++; $display("FAIL reset_mid_wait: outputs=%h required 0", all_outs());
        end
        m0_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < TO + 4; i++) begin
            bus_dv = (i == 2);
            @(posedge clk); #1;
            if (o_m0_DV || o_m1_DV || o_bus_DV) seen = 1'b1;
        end
        bus_dv = 1'b0;
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL reset_no_resp: pulse seen=%b required 0", seen); end
        prio_model = 1'b0;
    endtask

    task automatic test_contention();
        int il, rl; logic [68:0] sn, eb; logic ro, re, st, qu; logic [31:0] rd;
        logic exp_o;
        m0_address = 32'hA0; m1_address = 32'hB0;
        for (int t = 0; t < 4; t++) begin
            exp_o = prio_model;
            eb = exp_bus(exp_o);
            run_txn(1'b1, 1'b1, t, 32'h5000 + t, 1'b1, 1'b0, il, sn, rl, ro, rd, re, st, qu);
            checks++;
            if ({il, sn, ro} !== {32'd1, eb, exp_o}) begin
                failures++; $display("FAIL contention_%0d: issue=%0d bus=%h owner=%b required 1 %h %b",
                                     t, il, sn, ro, eb, exp_o);
            end
            checks++;
            if ({rl, rd, re, qu} !== {exp_resp_lat(t), 32'h5000 + t, 1'b0, 1'b1}) begin
                failures++; $display("FAIL contention_resp_%0d: lat=%0d data=%h err=%b quiet=%b", t, rl, rd, re, qu);
            end
            prio_model = ~exp_o;
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic test_timeout();
        int il, rl; logic [68:0] sn; logic ro, re, st, qu; logic [31:0] rd;
        logic seen = 1'b0;
        m0_address = 32'h500;
        run_txn(1'b1, 1'b0, 1000, 32'h0, 1'b0, 1'b0, il, sn, rl, ro, rd, re, st, qu);
        checks++;
        if ({rl, ro, rd, re} !== {TO + 1, 1'b0, 32'd0, 1'b1}) begin
            failures++; $display("FAIL timeout_resp: lat=%0d owner=%b data=%h err=%b required %0d 0 0 1",
                                 rl, ro, rd, re, TO + 1);
        end
        checks++;
        if (o_m0_err !== 1'b0) begin failures++; $display("FAIL timeout_err_clear: err=%b required 0", o_m0_err); end
        bus_dv = 1'b1; bus_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        bus_dv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (o_m0_DV || o_m1_DV || o_bus_DV) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if ({seen, o_m0_data} !== {1'b0, 32'd0}) begin
            failures++; $display("FAIL stray_bus_dv: pulse=%b m0_data=%h required 0 0", seen, o_m0_data);
        end
        prio_model = 1'b1;
        // Answer on the very last WAIT cycle is a success.
        run_txn(1'b1, 1'b0, TO - 1, 32'hC0FFEE00, 1'b0, 1'b0, il, sn, rl, ro, rd, re, st, qu);
        checks++;
        if ({rl, rd, re} !== {TO + 1, 32'hC0FFEE00, 1'b0}) begin
            failures++; $display("FAIL last_cycle_ok: lat=%0d data=%h err=%b required %0d c0ffee00 0",
                                 rl, rd, re, TO + 1);
        end
        prio_model = 1'b1;
    endtask

    task automatic test_field_stability();
        int il, rl; logic [68:0] sn; logic ro, re, st, qu; logic [31:0] rd;
        m0_address = 32'h10;
        run_txn(1'b1, 1'b0, 3, 32'h77, 1'b0, 1'b1, il, sn, rl, ro, rd, re, st, qu);
        checks++;
        if ({sn[67:36], st, o_bus_address} !== {32'h10, 1'b1, 32'h10}) begin
            failures++; $display("FAIL field_hold: addr=%h stable=%b now=%h required 10 1 10", sn[67:36], st, o_bus_address);
        end
        run_txn(1'b1, 1'b0, 0, 32'h78, 1'b0, 1'b0, il, sn, rl, ro, rd, re, st, qu);
        checks++;
        if (sn[67:36] !== 32'h20) begin failures++; $display("FAIL field_new_grant: addr=%h required 20", sn[67:36]); end
        prio_model = 1'b1;
    endtask

    task automatic test_random();
        int il, rl, lat; logic [68:0] sn, eb; logic ro, re, st, qu; logic [31:0] rd, rv;
        logic r0, r1, pend0, pend1, exp_o;
        pend0 = 1'b0; pend1 = 1'b0;
        for (int t = 0; t < 24; t++) begin
            r0 = pend0 | 1'($urandom);
            r1 = pend1 | 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            if (!pend0) begin m0_address = $urandom; m0_data = $urandom; m0_bhw = 3'($urandom); m0_wnr = 1'($urandom); end
            if (!pend1) begin m1_address = $urandom; m1_data = $urandom; m1_bhw = 3'($urandom); m1_wnr = 1'($urandom); end
            exp_o = (r0 && r1) ? prio_model : r1;
            eb    = exp_bus(exp_o);
            lat   = $urandom_range(0, TO);
            rv    = $urandom;
            run_txn(r0, r1, lat, rv, 1'b0, 1'b0, il, sn, rl, ro, rd, re, st, qu);
            checks++;
            if ({il, sn, ro, rl} !== {32'd1, eb, exp_o, exp_resp_lat(lat)}) begin
                failures++; $display("FAIL random_%0d_grant: issue=%0d bus=%h owner=%b lat=%0d required 1 %h %b %0d",
                                     t, il, sn, ro, rl, eb, exp_o, exp_resp_lat(lat));
            end
            checks++;
            if ({rd, re, st, qu} !== {(lat < TO) ? rv : 32'd0, lat >= TO, 1'b1, 1'b1}) begin
                failures++; $display("FAIL random_%0d_resp: data=%h err=%b stable=%b quiet=%b lat=%0d",
                                     t, rd, re, st, qu, lat);
            end
            prio_model = ~exp_o;
            pend0 = r0 && exp_o;
            pend1 = r1 && !exp_o;
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_reset_mid_wait();
        test_contention();
        test_timeout();
        test_field_stability();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the system memory bus.
- Master 0 is the CPU load/store/fetch port; master 1 is a secondary requester, e.g. a boot loader or DMA engine.
- Grants the bus one transaction at a time and drives the shared bus signals (address, data, bhw, write_notread, DV).
- Routes the slave's response data and DV back only to the owning master. A timeout guards against a slave that never answers.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles in WAIT without i_bus_DV before the transaction is aborted. Must be >= 2.
- CNT_W, 11: width of the timeout counter. Must be >= clog2(TIMEOUT_CYCLES+1).

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_m0_req  input  1  master 0 request; level, held until o_m0_DV
- i_m0_address  input  32  master 0 byte address
- i_m0_data  input  32  master 0 write data
- i_m0_bhw  input  3  master 0 byte/half/word select
- i_m0_write_notread  input  1  master 0 direction (1 = write)
- o_m0_data  output  32  response data to master 0
- o_m0_DV  output  1  one-cycle response pulse to master 0
- o_m0_err  output  1  valid with o_m0_DV; 1 = timed out
- i_m1_req, i_m1_address, i_m1_data, i_m1_bhw, i_m1_write_notread  inputs  1/32/32/3/1  master 1 request, same meaning as master 0
- o_m1_data, o_m1_DV, o_m1_err  outputs  32/1/1  master 1 response, same meaning as master 0
- o_bus_address  output  32  address to slave
- o_bus_data  output  32  write data to slave
- o_bus_bhw  output  3  size select to slave
- o_bus_write_notread  output  1  direction to slave
- o_bus_DV  output  1  one-cycle command pulse to slave
- i_bus_data  input  32  slave read data
- i_bus_DV  input  1  slave completion pulse
- o_owner  output  1  current or last bus owner (0/1), for debug

Behaviour:
- All outputs are registered. States: IDLE, ISSUE, WAIT, RESP.
- Reset (i_rst high, asynchronous):
  - state = IDLE; every output = 0; o_owner = 0.
  - Priority pointer = master 0; timeout counter = 0.
  - Reset asserted mid-transaction abandons it; no response pulse is produced.
- IDLE:
  - Neither request high: stay in IDLE.
  - One request high: latch that master's address, data, bhw and write_notread into the o_bus_* registers, set o_owner, go to ISSUE.
  - Both requests high: grant the master the priority pointer selects. After reset, master 0 wins.
- ISSUE:
  - o_bus_DV = 1 for exactly this cycle; bus fields are already stable. Next state is WAIT.
  - Request-seen to o_bus_DV latency is 1 cycle.
- WAIT:
  - o_bus_DV = 0; the o_bus_* fields are held constant until the next grant.
  - Timeout counter increments each WAIT cycle.
  - i_bus_DV = 1: capture i_bus_data, err = 0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 with no i_bus_DV: data = 0, err = 1, go to RESP.
  - i_bus_DV on the final timeout cycle counts as success.
- RESP:
  - Owner's o_mX_DV = 1 for one cycle, with o_mX_data and o_mX_err valid. The other master sees nothing.
  - Counter clears; priority pointer is set to the non-owner (round-robin); next state is IDLE.
- Response timing:
  - i_bus_DV to o_mX_DV latency is 1 cycle.
  - o_mX_data holds its value until the next response to that master.
  - o_mX_err clears with the DV pulse.
- Request handling rules:
  - Requests are never sampled in ISSUE, WAIT or RESP.
  - A master drops req in the cycle it sees its DV pulse. Req still high in the following IDLE cycle is treated as a new request.
  - i_bus_DV outside WAIT is ignored; no response is generated.
- Request field changes: changes to a master's address or data after grant do not affect the transaction in flight.
- Minimum transaction length: 4 cycles (IDLE, ISSUE, WAIT, RESP) with a 0-wait slave. Back-to-back transactions have no dead cycles beyond that.

Test Plan:
- Reset: assert i_rst mid-WAIT -> all outputs 0 immediately (asynchronous); state IDLE; no o_m0_DV/o_m1_DV afterwards.
- Single read, m0: address 0x00000100, bhw = 3'b010, write_notread = 0; slave returns 0xDEADBEEF 2 cycles after o_bus_DV -> o_bus_DV pulses 1 cycle after req; o_m0_DV pulses 1 cycle after i_bus_DV with o_m0_data = 0xDEADBEEF, o_m0_err = 0; o_m1_DV stays 0.
- Single write, m1: address 0x00000040, data 0x12345678, write_notread = 1 -> o_bus_address = 0x40, o_bus_data = 0x12345678, o_bus_write_notread = 1 during ISSUE; o_m1_DV pulses after i_bus_DV; o_owner = 1.
- Contention: both req high continuously for 4 transactions from reset -> grant order m0, m1, m0, m1; each o_bus_DV preceded by the correct owner's address.
- Timeout: TIMEOUT_CYCLES = 8, slave never answers -> o_m0_DV with o_m0_err = 1 and o_m0_data = 0 exactly 8 WAIT cycles after o_bus_DV. A later i_bus_DV in IDLE is ignored.
- Field stability: m0 changes i_m0_address from 0x10 to 0x20 during WAIT -> o_bus_address stays 0x10 until RESP completes.
